// File: rtl/irq_arbiter.sv
// irq_arbiter: interrupt pending/mask/priority logic with a single
// outstanding request toward pipeline control and a memory-mapped
// register block (PEND, MASK, CTRL, CAUSE).
// Optional feature macro: IRQ_ROUND_ROBIN_EN selects round-robin
// arbitration instead of fixed lowest-index priority.
module irq_arbiter #(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] ADDR_BASE = 32'h4000_0030
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    output logic             irq_req,
    input  logic             irq_ack,
    input  logic             irq_ret,
    output logic [2:0]       irq_cause,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;
    logic             r_gie;
    logic [N_SRC-1:0] r_src_prev;
    logic [2:0]       r_cause;

    logic [31:0]      w_off;
    logic             w_hit;
    logic [1:0]       w_sel;
    logic             w_wr_pend;
    logic             w_wr_mask;
    logic             w_wr_ctrl;
    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_cause_oh;
    logic             w_ack;
    logic [N_SRC-1:0] w_pend_nxt;
    logic [N_SRC-1:0] w_mask_nxt;
    logic             w_gie_nxt;
    logic [N_SRC-1:0] w_elig;
    logic [2:0]       w_winner;
    logic             w_grant;
    logic             w_unused;

    // Only the low data bits land in registers; the rest are don't-care.
    assign w_unused = ^wdata[31:N_SRC];

    // Bus decode: four word registers starting at ADDR_BASE.
    assign w_off     = addr - ADDR_BASE;
    assign w_hit     = (w_off < 32'd16);
    assign w_sel     = w_off[3:2];
    assign w_wr_pend = wr && w_hit && (w_sel == 2'd0);
    assign w_wr_mask = wr && w_hit && (w_sel == 2'd1);
    assign w_wr_ctrl = wr && w_hit && (w_sel == 2'd2);

    // Pending update: new edges always win over software or ack clears.
    assign w_set      = src_irq & ~r_src_prev;
    assign w_w1c      = w_wr_pend ? wdata[N_SRC-1:0] : '0;
    assign w_cause_oh = N_SRC'(1) << r_cause;
    assign w_ack      = (r_state == S_REQ) && irq_ack;
    assign w_pend_nxt = (r_pend & ~w_w1c & ~(w_ack ? w_cause_oh : '0)) | w_set;
    assign w_mask_nxt = w_wr_mask ? wdata[N_SRC-1:0] : r_mask;
    assign w_gie_nxt  = w_wr_ctrl ? wdata[0] : r_gie;
    assign w_elig     = r_pend & r_mask & {N_SRC{r_gie}};

    assign irq_req   = (r_state == S_REQ);
    assign irq_cause = r_cause;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [2:0] r_last;

    // First eligible index strictly after the last serviced one, wrapping.
    function automatic logic [2:0] f_pick(input logic [N_SRC-1:0] e, input logic [2:0] last);
        logic [2:0] w;
        logic       found;
        int         idx;
        w     = 3'd0;
        found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(last) + k) % N_SRC;
            if (!found && (|(e & (N_SRC'(1) << idx)))) begin
                w     = 3'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign w_winner = f_pick(w_elig, r_last);

    // Last-serviced pointer advances when a request is acknowledged.
    always_ff @(posedge clk) begin
        if (reset)      r_last <= 3'(N_SRC - 1);
        else if (w_ack) r_last <= r_cause;
    end
`else
    // Fixed priority: lowest eligible index wins.
    function automatic logic [2:0] f_pick(input logic [N_SRC-1:0] e);
        logic [2:0] w;
        w = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (|(e & (N_SRC'(1) << i))) w = 3'(i);
        end
        return w;
    endfunction

    assign w_winner = f_pick(w_elig);
`endif

    // Next-state logic; withdraw looks at the post-write register values
    // so the request drops on the edge where the clearing write lands.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack)
                    w_state_nxt = S_SERVICE;
                else if (!(|(w_pend_nxt & w_cause_oh)) || !(|(w_mask_nxt & w_cause_oh)) || !w_gie_nxt)
                    w_state_nxt = S_IDLE;
            end
            S_SERVICE: begin
                if (irq_ret) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and the winner latched on grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cause <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_cause <= w_winner;
        end
    end

    // Source edge history and software-visible registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_prev <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_gie      <= 1'b0;
        end else begin
            r_src_prev <= src_irq;
            r_pend     <= w_pend_nxt;
            r_mask     <= w_mask_nxt;
            r_gie      <= w_gie_nxt;
        end
    end

    // Combinational read mux; unmapped bits and idle bus read as zero.
    always_comb begin
        rdata = 32'd0;
        if (rd && w_hit) begin
            case (w_sel)
                2'd0: rdata = 32'(r_pend);
                2'd1: rdata = 32'(r_mask);
                2'd2: rdata = {30'd0, (r_state != S_IDLE), r_gie};
                2'd3: rdata = {(r_state == S_SERVICE), 28'd0, r_cause};
                default: rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed testbench for irq_arbiter: register access, request latency,
// ack/ret handshake, withdraw, set-vs-clear priority, arbitration order
// and reset during service.
module tb_irq_arbiter;

    localparam logic [31:0] BASE = 32'h4000_0030;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic        irq_req;
    logic        irq_ack;
    logic        irq_ret;
    logic [2:0]  irq_cause;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    irq_arbiter #(.N_SRC(4), .ADDR_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .src_irq(src_irq), .irq_req(irq_req),
        .irq_ack(irq_ack), .irq_ret(irq_ret), .irq_cause(irq_cause),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rdchk(input string tag, input logic [3:0] off, input logic [31:0] exp);
        addr = BASE + 32'(off);
        rd   = 1'b1;
        #1;
        chk(tag, rdata, exp);
        rd   = 1'b0;
    endtask

    task automatic wreg(input logic [3:0] off, input logic [31:0] d);
        addr  = BASE + 32'(off);
        wdata = d;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
    endtask

    logic [2:0] rr_exp [4];

    initial begin
        reset = 1'b1; src_irq = 4'd0; irq_ack = 1'b0; irq_ret = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
`ifdef IRQ_ROUND_ROBIN_EN
        rr_exp = '{3'd0, 3'd1, 3'd0, 3'd1};
`else
        rr_exp = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
        tick(); tick();
        chk("rst_req", 32'(irq_req), 32'd0);
        chk("rst_cause", 32'(irq_cause), 32'd0);
        rdchk("rst_pend", 4'h0, 32'd0);
        rdchk("rst_mask", 4'h4, 32'd0);
        rdchk("rst_ctrl", 4'h8, 32'd0);
        chk("rd_idle_zero", rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Enable all sources and global enable
        wreg(4'h4, 32'hFFFF_FFFF);
        wreg(4'h8, 32'd1);
        rdchk("mask_rd", 4'h4, 32'hF);
        rdchk("ctrl_rd", 4'h8, 32'h1);

        // Single source 2: latency, ack, ret
        src_irq = 4'b0100; tick(); src_irq = 4'd0;
        chk("lat_req_n1", 32'(irq_req), 32'd0);
        rdchk("lat_pend_n1", 4'h0, 32'h4);
        tick();
        chk("lat_req_n2", 32'(irq_req), 32'd1);
        chk("lat_cause", 32'(irq_cause), 32'd2);
        rdchk("busy_req", 4'h8, 32'h3);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("ack_req", 32'(irq_req), 32'd0);
        rdchk("ack_pend", 4'h0, 32'h0);
        rdchk("ack_cause", 4'hC, 32'h8000_0002);
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        rdchk("ret_busy", 4'h8, 32'h1);

        // Sources 1 and 3 together: 1 first, then 3 after a 1-cycle gap
        src_irq = 4'b1010; tick(); src_irq = 4'd0; tick();
        chk("pri_req", 32'(irq_req), 32'd1);
        chk("pri_cause1", 32'(irq_cause), 32'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        rdchk("pri_pend_left", 4'h0, 32'h8);
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        chk("gap_req", 32'(irq_req), 32'd0);
        tick();
        chk("pri_req3", 32'(irq_req), 32'd1);
        chk("pri_cause3", 32'(irq_cause), 32'd3);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        rdchk("pri_done", 4'h8, 32'h1);

        // Withdraw by W1C of the pending winner
        src_irq = 4'b0001; tick(); src_irq = 4'd0; tick();
        chk("wd_req_up", 32'(irq_req), 32'd1);
        wreg(4'h0, 32'h1);
        chk("wd_req_down", 32'(irq_req), 32'd0);
        rdchk("wd_idle", 4'h8, 32'h1);
        rdchk("wd_pend", 4'h0, 32'h0);

        // Ack in the same cycle as W1C: ack wins
        src_irq = 4'b0001; tick(); src_irq = 4'd0; tick();
        chk("ackw_req_up", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; wreg(4'h0, 32'h1); irq_ack = 1'b0;
        chk("ackw_req", 32'(irq_req), 32'd0);
        rdchk("ackw_svc", 4'hC, 32'h8000_0000);
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;

        // Edge and W1C on the same bit in one cycle: set wins
        wreg(4'h8, 32'd0);
        src_irq = 4'b0100; wreg(4'h0, 32'h4); src_irq = 4'd0;
        rdchk("setw_pend", 4'h0, 32'h4);
        tick();
        chk("setw_nogie_req", 32'(irq_req), 32'd0);
        wreg(4'h0, 32'hF);
        rdchk("setw_clr", 4'h0, 32'h0);

        // Masked source: pending sets but no request
        wreg(4'h4, 32'd0);
        wreg(4'h8, 32'd1);
        src_irq = 4'b0010; tick(); src_irq = 4'd0; tick(); tick();
        chk("mask_req", 32'(irq_req), 32'd0);
        rdchk("mask_pend", 4'h0, 32'h2);
        wreg(4'h0, 32'hF);
        wreg(4'h4, 32'hF);

        // Sources 0 and 1 held pending, served one re-fired each round
        src_irq = 4'b0011; tick(); src_irq = 4'd0; tick();
        for (int i = 0; i < 4; i++) begin
            chk("arb_req", 32'(irq_req), 32'd1);
            chk("arb_cause", 32'(irq_cause), 32'(rr_exp[i]));
            irq_ack = 1'b1; tick(); irq_ack = 1'b0;
            irq_ret = 1'b1; src_irq = 4'(1) << irq_cause; tick();
            irq_ret = 1'b0; src_irq = 4'd0; tick();
        end

        // Reset during SERVICE
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        rdchk("svc_before_rst", 4'h8, 32'h3);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_svc_req", 32'(irq_req), 32'd0);
        rdchk("rst_svc_mask", 4'h4, 32'h0);
        rdchk("rst_svc_ctrl", 4'h8, 32'h0);
        rdchk("rst_svc_pend", 4'h0, 32'h0);
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        rdchk("ret_ignored", 4'h8, 32'h0);
        chk("ret_ignored_req", 32'(irq_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt controller and scheduler for the pipelined MIPS core. Collects interrupt sources from the peripherals (timer, UART RX, UART TX, switch change), latches them as pending, masks and prioritises them, and raises one request at a time toward the pipeline control. It then holds off further requests until the pipeline reports the handler has returned. Its control registers are memory-mapped on the same rd/wr/addr/wdata/rdata data bus the MEM stage uses for peripherals.

## Interface

- N_SRC, 4, number of interrupt sources (1..8)
- ADDR_BASE, 32'h4000_0030, byte address of register block (4 words)

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- src_irq  in  N_SRC  raw source lines; rising edge sets pending
- irq_req  out  1  registered interrupt request to Control
- irq_ack  in  1  one-cycle pulse: pipeline has committed the vector jump
- irq_ret  in  1  one-cycle pulse: handler return committed
- irq_cause  out  3  index of source being requested or serviced
- rd  in  1  bus read strobe
- wr  in  1  bus write strobe
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- rdata  out  32  bus read data, combinational

## Operation

- Registers: +0 PEND (bits [N_SRC-1:0]; read; write-1-to-clear), +4 MASK (RW, reset 0), +8 CTRL (bit0 GIE RW reset 0; bit1 BUSY RO = state≠IDLE), +C CAUSE (RO; [2:0] irq_cause, bit31 = state==SERVICE).
- rdata = selected register, zero-extended, when rd and addr within block; else 0. Unmapped bits read 0.
- Edge detect: src_prev registered each cycle, reset to 0; pend[i] set when src_irq[i] & ~src_prev[i]. A source already high after reset is taken as one edge.
- Same-cycle set and W1C on one bit: set wins.
- Eligible = PEND & MASK, gated by GIE.
- FSM:
  - IDLE: if eligible≠0, latch winner into irq_cause and go to REQ. Winner is the lowest-index eligible bit.
  - REQ: irq_req=1. The winner is frozen; later or higher sources do not preempt it.
    - On irq_ack: clear pend[winner] and go to SERVICE.
    - Else if pend[winner] is cleared by software, or MASK[winner]=0, or GIE=0: withdraw to IDLE.
    - irq_ack wins over any same-cycle withdraw condition.
  - SERVICE: irq_req=0; no nesting. On irq_ret, go to IDLE.
- irq_ack outside REQ and irq_ret outside SERVICE are ignored.

## Timing

- Reset values: irq_req=0, irq_cause=0, PEND=0, MASK=0, GIE=0, state=IDLE, src_prev=0. rdata follows its combinational rule.
- Request latency:
  - rising edge sampled at edge n → PEND bit visible in cycle n+1;
  - IDLE→REQ at edge n+1;
  - irq_req high from cycle n+2 (2 cycles after sampling).
- irq_ack in REQ at edge k: irq_req low from cycle k+1; PEND bit clear in cycle k+1.
- irq_ret at edge k: IDLE in cycle k+1. The earliest next irq_req is cycle k+2, so there is a minimum 1-cycle gap.
- Withdraw: irq_req low the cycle after the clearing write/mask/GIE change takes effect.
- Bus writes take effect at the rising edge where wr=1; reads are same-cycle.
- Reset asserted in any state: next cycle is IDLE with all registers at reset values; any in-flight request is dropped.

## Configuration

- IRQ_ROUND_ROBIN_EN defined:
  - The winner is the first eligible index strictly after the last serviced index, wrapping modulo N_SRC.
  - The last-serviced pointer resets to N_SRC-1, so the first grant favours index 0.
  - The pointer updates on irq_ack.
- Undefined: fixed priority, lowest index wins, and no pointer register exists.

## Test plan

- Reset, MASK=4'hF, GIE=1; pulse src_irq[2] → irq_req=1 two cycles after the edge, irq_cause=2; irq_ack → irq_req=0, PEND=0, CAUSE bit31=1; irq_ret → BUSY=0.
- Fire src 1 and 3 in the same cycle, fixed priority → cause 1 served first; after irq_ret plus a 1-cycle gap, cause 3 is requested.
- In REQ for src 0, write PEND=1 (W1C) → irq_req drops next cycle and state returns to IDLE. Repeat with irq_ack in the same cycle → ack wins, state goes to SERVICE.
- Source edge and W1C of the same bit in one cycle → PEND bit stays 1. MASK=0 with an edge → PEND sets but irq_req stays 0.
- IRQ_ROUND_ROBIN_EN, sources 0 and 1 held pending and re-fired each service → grants alternate 0,1,0,1.
- Assert reset during SERVICE → next cycle irq_req=0, MASK=0, BUSY=0; irq_ret afterwards is ignored.
